// File: rtl/ssp_pkg.sv
// Shared SSP definitions: data width, receive FIFO depth, FIFO occupancy
// states and the pointer-width helper used by the receive FIFO slice.
package ssp_pkg;

  localparam int SSP_DATA_W   = 8;
  localparam int SSP_RX_DEPTH = 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } rxState_t;

  // Pointer width for a power-of-two depth; never narrower than one bit
  function automatic int ptrWidth(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ssp_fifo_mem.sv
// Byte store for the SSP receive FIFO: DEPTH x WIDTH registers with one
// synchronous write port and one registered read port. Only the read
// register is reset; the storage array itself is not.
module ssp_fifo_mem
  import ssp_pkg::*;
#(
  parameter int DEPTH = SSP_RX_DEPTH,
  parameter int WIDTH = SSP_DATA_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_we,
  input  logic [ptrWidth(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_re,
  input  logic [ptrWidth(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]           o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage write; contents survive reset and are simply overwritten later
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register holds its value between reads so the bus sees stable data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ssp_rx_fifo_ctrl.sv
// SSP receive FIFO controller: buffers bytes from the receive shifter and
// serves APB-style reads with one cycle of latency. Occupancy is tracked
// as EMPTY / PARTIAL / FULL with registered flags.
// Optional build macro SSP_RX_OVERRUN_EN adds a sticky rx_overrun output
// that flags bytes dropped while full.
module ssp_rx_fifo_ctrl
  import ssp_pkg::*;
#(
  parameter int DEPTH = SSP_RX_DEPTH,
  parameter int WIDTH = SSP_DATA_W
) (
  input  logic             PCLK,
  input  logic             CLEAR_B,
  input  logic             PSEL,
  input  logic             PWRITE,
  output logic [WIDTH-1:0] PRDATA,
  input  logic             write_fifo,
  input  logic [WIDTH-1:0] RxData,
  output logic             rx_fifo_full,
  output logic             SSPRXINTR,
  output logic             rx_fifo_empty
`ifdef SSP_RX_OVERRUN_EN
  ,
  output logic             rx_overrun
`endif
);

  localparam int PTR_W = ptrWidth(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W-1:0] r_wptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_countNext;
  rxState_t         r_state;
  rxState_t         w_stateNext;
  logic             r_full;
  logic             r_empty;
  logic             w_fullNext;
  logic             w_emptyNext;
  logic             w_rdAcc;
  logic             w_wrAcc;

  // A read frees a slot, so a write while full still goes in when paired with one
  assign w_rdAcc = PSEL && !PWRITE && (r_state != EMPTY);
  assign w_wrAcc = write_fifo && ((r_state != FULL) || w_rdAcc);

  // Pointers and occupancy count follow the accepted operations
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wrAcc) r_wptr <= r_wptr + PTR_W'(1);
      if (w_rdAcc) r_rptr <= r_rptr + PTR_W'(1);
      r_count <= w_countNext;
    end
  end

  // State register; flags are registered alongside so they match count
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      r_state <= EMPTY;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_state <= w_stateNext;
      r_full  <= w_fullNext;
      r_empty <= w_emptyNext;
    end
  end

  // Next count and next occupancy state from this cycle's accepted operations
  always_comb begin
    w_countNext = r_count;
    case ({w_wrAcc, w_rdAcc})
      2'b10:   w_countNext = r_count + CNT_W'(1);
      2'b01:   w_countNext = r_count - CNT_W'(1);
      default: w_countNext = r_count;
    endcase
    w_stateNext = r_state;
    case (r_state)
      EMPTY: begin
        if (w_wrAcc) begin
          w_stateNext = (w_countNext == CNT_W'(DEPTH)) ? FULL : PARTIAL;
        end
      end
      PARTIAL: begin
        if (w_countNext == CNT_W'(DEPTH)) begin
          w_stateNext = FULL;
        end else if (w_countNext == '0) begin
          w_stateNext = EMPTY;
        end
      end
      FULL: begin
        if (w_rdAcc && !w_wrAcc) begin
          w_stateNext = PARTIAL;
        end
      end
      default: w_stateNext = EMPTY;
    endcase
  end

  // Flag values to be registered, decoded from the next state
  always_comb begin
    w_fullNext  = (w_stateNext == FULL);
    w_emptyNext = (w_stateNext == EMPTY);
  end

  assign rx_fifo_full  = r_full;
  assign SSPRXINTR     = r_full;
  assign rx_fifo_empty = r_empty;

`ifdef SSP_RX_OVERRUN_EN
  logic r_overrun;
  logic w_drop;

  assign w_drop = write_fifo && (r_state == FULL) && !w_rdAcc;

  // Sticky overrun: a drop sets it (winning over clear), an accepted read clears it
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (w_rdAcc) begin
      r_overrun <= 1'b0;
    end
  end

  assign rx_overrun = r_overrun;
`endif

  ssp_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .i_clk   (PCLK),
    .i_rst_n (CLEAR_B),
    .i_we    (w_wrAcc),
    .i_waddr (r_wptr),
    .i_wdata (RxData),
    .i_re    (w_rdAcc),
    .i_raddr (r_rptr),
    .o_rdata (PRDATA)
  );

endmodule

// File: tb/tb_ssp_rx_fifo_ctrl.sv
// Testbench for ssp_rx_fifo_ctrl: directed vectors push the expected
// PRDATA for each read into a scoreboard queue; a monitor pops and
// compares one cycle after each read. Flags are checked directly.
module tb_ssp_rx_fifo_ctrl;

  logic       PCLK;
  logic       CLEAR_B;
  logic       PSEL;
  logic       PWRITE;
  logic [7:0] PRDATA;
  logic       write_fifo;
  logic [7:0] RxData;
  logic       rx_fifo_full;
  logic       SSPRXINTR;
  logic       rx_fifo_empty;
`ifdef SSP_RX_OVERRUN_EN
  logic       rx_overrun;
`endif

  logic [7:0] expQ [$];
  int         passCount  = 0;
  int         totalCount = 0;

  ssp_rx_fifo_ctrl #(
    .DEPTH (4),
    .WIDTH (8)
  ) dut (
    .PCLK          (PCLK),
    .CLEAR_B       (CLEAR_B),
    .PSEL          (PSEL),
    .PWRITE        (PWRITE),
    .PRDATA        (PRDATA),
    .write_fifo    (write_fifo),
    .RxData        (RxData),
    .rx_fifo_full  (rx_fifo_full),
    .SSPRXINTR     (SSPRXINTR),
    .rx_fifo_empty (rx_fifo_empty)
`ifdef SSP_RX_OVERRUN_EN
    ,
    .rx_overrun    (rx_overrun)
`endif
  );

  // Free-running 10 ns clock
  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One-cycle strobe: drive at negedge, hold through the posedge, then idle
  task automatic applyStimulus(input logic wr, input logic [7:0] data,
                               input logic rd, input logic [7:0] expData);
    @(negedge PCLK);
    write_fifo = wr;
    RxData     = data;
    PSEL       = rd;
    PWRITE     = 1'b0;
    if (rd) expQ.push_back(expData);
    @(posedge PCLK);
    #1;
    write_fifo = 1'b0;
    PSEL       = 1'b0;
  endtask

  // Compare the three flags against hand-computed values
  task automatic checkOutput(input string name, input logic expFull, input logic expEmpty);
    totalCount++;
    if ({rx_fifo_full, SSPRXINTR, rx_fifo_empty} === {expFull, expFull, expEmpty}) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: full/intr/empty got %b%b%b expected %b%b%b", name,
               rx_fifo_full, SSPRXINTR, rx_fifo_empty, expFull, expFull, expEmpty);
    end
  endtask

  task automatic checkData(input string name, input logic [7:0] expData);
    totalCount++;
    if (PRDATA === expData) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: PRDATA got %h expected %h", name, PRDATA, expData);
    end
  endtask

`ifdef SSP_RX_OVERRUN_EN
  task automatic checkOverrun(input string name, input logic expOvr);
    totalCount++;
    if (rx_overrun === expOvr) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: rx_overrun got %b expected %b", name, rx_overrun, expOvr);
    end
  endtask
`endif

  // Monitor: a read seen at a posedge produces data checked at the next negedge
  initial begin
    logic       rdSampled;
    logic [7:0] expData;
    forever begin
      @(posedge PCLK);
      rdSampled = PSEL && !PWRITE && CLEAR_B;
      @(negedge PCLK);
      if (rdSampled) begin
        totalCount++;
        if (expQ.size() == 0) begin
          $display("[TB] FAIL readData: got %h with no expected entry queued", PRDATA);
        end else begin
          expData = expQ.pop_front();
          if (PRDATA === expData) begin
            passCount++;
          end else begin
            $display("[TB] FAIL readData: PRDATA got %h expected %h", PRDATA, expData);
          end
        end
      end
    end
  end

  // Directed test sequence
  initial begin
    CLEAR_B    = 1'b0;
    PSEL       = 1'b0;
    PWRITE     = 1'b0;
    write_fifo = 1'b0;
    RxData     = 8'h00;
    repeat (3) @(negedge PCLK);
    CLEAR_B = 1'b1;
    @(negedge PCLK);
    checkOutput("resetFlags", 1'b0, 1'b1);
    checkData("resetData", 8'h00);
`ifdef SSP_RX_OVERRUN_EN
    checkOverrun("resetOverrun", 1'b0);
`endif

    // Two writes then two reads in order
    applyStimulus(1'b1, 8'hA5, 1'b0, 8'h00);
    applyStimulus(1'b1, 8'h3C, 1'b0, 8'h00);
    checkOutput("twoStored", 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'hA5);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h3C);
    checkOutput("drainedTwo", 1'b0, 1'b1);

    // Read while empty holds data; write+read while empty accepts only the write
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h3C);
    checkOutput("emptyRead", 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h77, 1'b1, 8'h3C);
    checkOutput("emptyWrRd", 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h77);
    checkOutput("after77", 1'b0, 1'b1);

    // Fill, then a dropped write while full
    applyStimulus(1'b1, 8'h01, 1'b0, 8'h00);
    applyStimulus(1'b1, 8'h02, 1'b0, 8'h00);
    applyStimulus(1'b1, 8'h03, 1'b0, 8'h00);
    checkOutput("threeStored", 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h04, 1'b0, 8'h00);
    checkOutput("nowFull", 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h05, 1'b0, 8'h00);
    checkOutput("dropKeepsFull", 1'b1, 1'b0);
`ifdef SSP_RX_OVERRUN_EN
    checkOverrun("overrunSet", 1'b1);
`endif
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h01);
    checkOutput("fullToPartial", 1'b0, 1'b0);
`ifdef SSP_RX_OVERRUN_EN
    checkOverrun("overrunCleared", 1'b0);
`endif
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h02);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h03);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h04);
    checkOutput("drainedFour", 1'b0, 1'b1);

    // Simultaneous read and write while full
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0, 8'h00);
    end
    checkOutput("fullAgain", 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h14, 1'b1, 8'h10);
    checkOutput("fullWrRd", 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h11);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h12);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h13);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h14);
    checkOutput("drainedWrap", 1'b0, 1'b1);

    // Asynchronous reset with three entries stored
    applyStimulus(1'b1, 8'h20, 1'b0, 8'h00);
    applyStimulus(1'b1, 8'h21, 1'b0, 8'h00);
    applyStimulus(1'b1, 8'h22, 1'b0, 8'h00);
    checkOutput("preReset", 1'b0, 1'b0);
    #2;
    CLEAR_B = 1'b0;
    #1;
    checkOutput("asyncReset", 1'b0, 1'b1);
    checkData("asyncResetData", 8'h00);
    @(posedge PCLK);
    #1;
    CLEAR_B = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h00);
    checkOutput("postResetRead", 1'b0, 1'b1);

    // Let the monitor consume the last expectation, then make sure nothing is left over
    repeat (3) @(negedge PCLK);
    totalCount++;
    if (expQ.size() == 0) begin
      passCount++;
    end else begin
      $display("[TB] FAIL scoreboardDrain: %0d entries left, expected 0", expQ.size());
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/ssp_rx_fifo_ctrl.md
Name: ssp_rx_fifo_ctrl

Overview:
- Receive-FIFO controller for the SSP block. Sits between the serial receive shifter and the APB-style parallel read interface.
- Accepts assembled bytes on a one-cycle write strobe and buffers them in a DEPTH-entry circular store.
- Serves processor reads and drives the full indication back to the shifter and to SSPRXINTR.
- Sequences occupancy through EMPTY / PARTIAL / FULL states.

Parameters:
- DEPTH, 4, number of byte entries; power of two, minimum 2.
- WIDTH, 8, data width in bits.

Ports:
- PCLK  in  1  system clock; all state updates on the posedge.
- CLEAR_B  in  1  reset, asynchronous, active-low.
- PSEL  in  1  chip select.
- PWRITE  in  1  1 = write cycle (ignored by this block), 0 = read cycle.
- PRDATA  out  WIDTH  registered read data.
- write_fifo  in  1  one-cycle strobe from the receive shifter: RxData is valid.
- RxData  in  WIDTH  byte from the receive shifter.
- rx_fifo_full  out  1  FIFO full, returned to the receive shifter.
- SSPRXINTR  out  1  receive FIFO full interrupt.
- rx_fifo_empty  out  1  FIFO empty.

Behaviour:
- Clocking and reset: one clock, PCLK, posedge. CLEAR_B is asynchronous active-low.
- Reset values:
  - PRDATA = 0; rx_fifo_full = 0; SSPRXINTR = 0; rx_fifo_empty = 1.
  - Read pointer, write pointer and count = 0; state = EMPTY.
- Counters:
  - Pointers are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is clog2(DEPTH)+1 bits, range 0..DEPTH.
- Write accept: write_fifo=1 and (state != FULL, or a read is accepted in the same cycle).
  - mem[wptr] <= RxData; wptr increments.
- Read accept: PSEL=1, PWRITE=0 and state != EMPTY.
  - PRDATA <= mem[rptr] on that edge, so data is visible the cycle after the request (1-cycle latency); rptr increments.
  - Each PCLK cycle with PSEL=1 and PWRITE=0 counts as one read.
- Read while EMPTY: ignored; PRDATA holds its last value; no pointer movement.
- Write while FULL with no read: byte dropped; pointers and count unchanged.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
  - EMPTY: only the write is accepted; there is no fall-through.
  - FULL: both are accepted; the read returns the oldest entry, the new byte fills the freed slot, and state stays FULL.
- State transitions (taken on the edge, based on the accepted operations):
  - EMPTY -> PARTIAL on a write (or -> FULL when DEPTH would be 1, which is disallowed).
  - PARTIAL -> FULL when count reaches DEPTH.
  - PARTIAL -> EMPTY when count reaches 0.
  - FULL -> PARTIAL on a read with no write.
- Flags: rx_fifo_full = SSPRXINTR = (state == FULL); rx_fifo_empty = (state == EMPTY). All three are registered and consistent with count in the same cycle.
- Reset mid-operation: contents are discarded, all state returns to reset values immediately, and memory contents need not be cleared.
- PWRITE=1 cycles never modify this block.

Optional Feature:
- Macro: SSP_RX_OVERRUN_EN.
- When defined:
  - Adds output rx_overrun (1 bit, reset 0).
  - rx_overrun sets on any dropped write (write_fifo=1, FULL, no read).
  - It is sticky and clears only on the next accepted read, or on reset.
  - Set has priority over clear when both occur in one cycle.
- When undefined: port absent, dropped writes are silent, and all other behaviour is identical.

Decomposition:
- Shared package ssp_pkg:
  - SSP_DATA_W = 8 and SSP_RX_DEPTH = 4 constants.
  - State typedef or encodings: EMPTY=2'd0, PARTIAL=2'd1, FULL=2'd2.
  - Width helper for the pointers.
- Sub-module ssp_fifo_mem: DEPTH x WIDTH register array with one synchronous write port and one registered read port, no reset on storage. The controller owns the pointers, count, state and flags.

Test Plan:
- Reset then idle -> PRDATA=0, rx_fifo_empty=1, rx_fifo_full=0, SSPRXINTR=0.
- Write 0xA5, 0x3C (one strobe each), then 2 reads -> PRDATA=0xA5 then 0x3C, each one cycle after its read; rx_fifo_empty=1 afterwards.
- Write 0x01..0x04, then strobe 0x05 -> full and SSPRXINTR=1 after the 4th write; 0x05 dropped; 4 reads return 0x01..0x04. With SSP_RX_OVERRUN_EN, rx_overrun=1 until the first read.
- FULL with 0x10..0x13, then read and write 0x14 in the same cycle -> PRDATA=0x10, still full; next reads return 0x11, 0x12, 0x13, 0x14.
- Read while empty after PRDATA=0x3C -> PRDATA stays 0x3C and pointers are unchanged. Simultaneous write 0x77 and read while empty -> PRDATA unchanged, count=1, next read returns 0x77.
- CLEAR_B low for 1 cycle with 3 entries stored (asynchronous, mid-cycle) -> flags return to reset values immediately; a subsequent read returns no data and PRDATA=0.
